// File: rtl/apb_req_master_if.sv
// Bus bundle for apb_req_master: request FIFO drain side, response FIFO fill side
// and the APB3 initiator segment. Master modport is the block itself.
interface apb_req_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REQ_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH
);
    logic                  req_empty;
    logic [REQ_WIDTH-1:0]  req_data;
    logic                  req_rd_en;
    logic                  rsp_full;
    logic                  rsp_wr_en;
    logic [DATA_WIDTH:0]   rsp_data;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        input  req_empty, req_data, rsp_full, pready, prdata, pslverr,
        output req_rd_en, rsp_wr_en, rsp_data, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_empty, req_data, rsp_full, pready, prdata, pslverr,
        input  req_rd_en, rsp_wr_en, rsp_data, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_req_master.sv
// APB3 initiator draining a FWFT request FIFO into single transfers, one outstanding,
// with completions pushed to a response FIFO. Optional ACCESS timeout: APB_TIMEOUT_EN.
module apb_req_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REQ_WIDTH      = 1 + ADDR_WIDTH + DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    apb_req_master_if.master      bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   launch_ok;
    logic   pop;
    logic   timeout;
    logic   complete;

    // Room is reserved at launch: this block is the response FIFO's only writer.
    assign launch_ok = !bus.req_empty && !bus.rsp_full;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt;

    // SETUP always precedes ACCESS, so clearing there clears on ACCESS entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !bus.pready && !timeout) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = (state == ACCESS) && !bus.pready && (wait_cnt == TIMEOUT_VAL);
`else
    localparam int timeout_cycles_unused = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    assign complete = (state == ACCESS) && (bus.pready || timeout);

    // NOTE: every output of this block is given a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        case (state)
            IDLE: begin
                if (launch_ok) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                bus.psel  = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
                if (complete) begin
                    if (launch_ok) begin
                        pop       = 1'b1;
                        state_nxt = SETUP;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reset only masks the pop strobe; the state register already sits in IDLE.
    assign bus.req_rd_en = pop && rst_n;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the datapath registers are reset too, because their reset value (zero)
    // is visible on the bus and the response port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pwrite <= 1'b0;
            bus.paddr  <= '0;
            bus.pwdata <= '0;
        end else if (pop) begin
            {bus.pwrite, bus.paddr, bus.pwdata} <= bus.req_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_wr_en <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_wr_en <= complete;
            if (complete) begin
                if (bus.pready) begin
                    bus.rsp_data <= {bus.pslverr, bus.pwrite ? {DATA_WIDTH{1'b0}} : bus.prdata};
                end else begin
                    bus.rsp_data <= {1'b1, {DATA_WIDTH{1'b0}}};
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: FIFO and APB slave models, scoreboard of
// expected responses filled when the slave completes and drained on rsp_wr_en.
module tb_apb_req_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 1 + AW + DW;
    localparam int TO = 16;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic [DW-1:0] rdata;
        logic          err;
    } xfer_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    apb_req_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REQ_WIDTH(RW)) bus ();

    apb_req_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .REQ_WIDTH     (RW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    logic [RW-1:0] req_q[$];
    xfer_t         xfer_q[$];
    logic [DW:0]   rsp_q[$];
    logic [1:0]    log_q[$];
    bit            log_en = 1'b0;
    int            checks = 0;
    int            failures = 0;
    int            pop_cnt = 0;
    int            rsp_cnt = 0;
    int            acc_len = 0;
    int            last_len = 0;
    xfer_t         cur;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void fifo_update();
        bus.req_empty = (req_q.size() == 0);
        bus.req_data  = (req_q.size() != 0) ? req_q[0] : '0;
    endfunction

    task automatic push_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int waits, input logic [DW-1:0] rd, input logic err);
        xfer_t x;
        x.write = w;
        x.addr  = a;
        x.wdata = d;
        x.waits = waits;
        x.rdata = rd;
        x.err   = err;
        req_q.push_back({w, a, d});
        xfer_q.push_back(x);
        fifo_update();
    endtask

    // Advance one cycle; the FIFO head moves if the DUT popped in the cycle just ended.
    task automatic tick();
        logic p;
        @(posedge clk);
        p = bus.req_rd_en;
        #1;
        if (p && req_q.size() != 0) void'(req_q.pop_front());
        fifo_update();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!(req_q.size() == 0 && xfer_q.size() == 0 && rsp_q.size() == 0 &&
                 !bus.psel && !bus.rsp_wr_en) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check({tag, "_idle_timeout"}, 1, 0);
    endtask

    // APB slave model and monitor, both on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus.pready  = 1'b0;
            bus.prdata  = '0;
            bus.pslverr = 1'b0;
            acc_len     = 0;
        end else begin
            if (log_en) log_q.push_back({bus.psel, bus.penable});
            if (bus.req_rd_en) begin
                check("pop_when_empty", bus.req_empty, 1'b0);
                pop_cnt++;
            end
            if (bus.rsp_wr_en) begin
                rsp_cnt++;
                if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else check("rsp_data", bus.rsp_data, rsp_q.pop_front());
            end
            if (bus.psel && !bus.penable) begin
                if (xfer_q.size() == 0) begin
                    check("setup_unexpected", 1, 0);
                end else begin
                    cur = xfer_q.pop_front();
                    check("setup_req", {bus.pwrite, bus.paddr, bus.pwdata},
                          {cur.write, cur.addr, cur.wdata});
                end
                acc_len     = 0;
                bus.pready  = 1'b1;
                bus.prdata  = $urandom;
                bus.pslverr = 1'($urandom_range(0, 1));
            end else if (bus.psel && bus.penable) begin
                acc_len++;
                check("access_hold", {bus.pwrite, bus.paddr, bus.pwdata},
                      {cur.write, cur.addr, cur.wdata});
                if (acc_len > cur.waits) begin
                    bus.pready  = 1'b1;
                    bus.prdata  = cur.write ? DW'($urandom) : cur.rdata;
                    bus.pslverr = cur.err;
                    rsp_q.push_back({cur.err, cur.write ? {DW{1'b0}} : cur.rdata});
                    last_len = acc_len;
                end else begin
                    bus.pready  = 1'b0;
                    bus.prdata  = $urandom;
                    bus.pslverr = 1'($urandom_range(0, 1));
`ifdef APB_TIMEOUT_EN
                    if (acc_len == TO + 1) begin
                        rsp_q.push_back({1'b1, {DW{1'b0}}});
                        last_len = acc_len;
                    end
`endif
                end
            end else begin
                bus.pready  = 1'($urandom_range(0, 1));
                bus.prdata  = $urandom;
                bus.pslverr = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        int r0;
        int idx;
        logic [13:0] pat;

        bus.rsp_full = 1'b0;
        fifo_update();
        repeat (3) tick();
        check("reset_outputs", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
                                bus.rsp_wr_en, bus.rsp_data, bus.req_rd_en}, '0);
        rst_n = 1'b1;
        tick();

        // Single write with latency checks.
        push_req(1'b1, 32'h10, 32'hA5A5_A5A5, 0, 32'h0, 1'b0);
        #3 check("pop_same_cycle", bus.req_rd_en, 1'b1);
        tick();
        #3 check("lat_setup", {bus.psel, bus.penable}, 2'b10);
        tick();
        #3 check("lat_access", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
                 {3'b111, 32'h10, 32'hA5A5_A5A5});
        tick();
        #3 check("lat_rsp", {bus.rsp_wr_en, bus.rsp_data}, {1'b1, 33'h0});
        tick();
        #3 check("rsp_single_pulse", bus.rsp_wr_en, 1'b0);
        wait_idle("write", 50);

        // Read with three wait states.
        push_req(1'b0, 32'h20, 32'h1111_2222, 3, 32'hDEAD_BEEF, 1'b0);
        wait_idle("read_ws", 50);
        check("read_access_len", last_len, 4);
        check("read_rsp_held", bus.rsp_data, {1'b0, 32'hDEAD_BEEF});

        // Back-to-back from a FIFO holding three requests.
        log_q.delete();
        log_en = 1'b1;
        p0 = pop_cnt;
        r0 = rsp_cnt;
        push_req(1'b0, 32'h30, 32'h0, 0, 32'hCAFE_0001, 1'b0);
        push_req(1'b1, 32'h34, 32'h7777_8888, 0, 32'h0, 1'b0);
        push_req(1'b0, 32'h38, 32'h0, 0, 32'hCAFE_0003, 1'b0);
        wait_idle("b2b", 50);
        log_en = 1'b0;
        idx = 0;
        while (idx < log_q.size() && log_q[idx][1] == 1'b0) idx++;
        if (idx + 7 > log_q.size()) begin
            check("b2b_log_len", log_q.size(), idx + 7);
        end else begin
            pat = {log_q[idx], log_q[idx+1], log_q[idx+2], log_q[idx+3],
                   log_q[idx+4], log_q[idx+5], log_q[idx+6]};
            check("b2b_pattern", pat, 14'b10_11_10_11_10_11_00);
        end
        check("b2b_pops", pop_cnt - p0, 3);
        check("b2b_rsps", rsp_cnt - r0, 3);

        // Backpressure from a full response FIFO.
        bus.rsp_full = 1'b1;
        push_req(1'b1, 32'h44, 32'h0102_0304, 1, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold", {bus.req_rd_en, bus.psel}, 2'b00);
        end
        bus.rsp_full = 1'b0;
        #1 check("bp_release_pop", bus.req_rd_en, 1'b1);
        tick();
        #1 check("bp_setup", {bus.psel, bus.penable}, 2'b10);
        wait_idle("bp", 50);

        // Slave error, then a clean read.
        push_req(1'b0, 32'h48, 32'h0, 2, 32'h0000_1234, 1'b1);
        push_req(1'b0, 32'h4C, 32'h0, 0, 32'h0000_55AA, 1'b0);
        wait_idle("slverr", 50);
        check("after_err_rsp", bus.rsp_data, {1'b0, 32'h0000_55AA});

        // Random mix with wait states.
        for (int i = 0; i < 8; i++) begin
            push_req(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 4),
                     $urandom, 1'($urandom_range(0, 1)));
        end
        wait_idle("random", 200);

        // Reset in the middle of ACCESS.
        push_req(1'b0, 32'h50, 32'h0, 1000, 32'h9999_9999, 1'b0);
        n = 0;
        while (!(bus.psel && bus.penable) && n < 20) begin
            tick();
            n++;
        end
        check("rst_reach_access", bus.psel && bus.penable, 1'b1);
        tick();
        tick();
        r0 = rsp_cnt;
        p0 = pop_cnt;
        #2 rst_n = 1'b0;
        #1 check("rst_async", {bus.psel, bus.penable}, 2'b00);
        push_req(1'b1, 32'h60, 32'h0BAD_F00D, 0, 32'h0, 1'b0);
        #1 check("rst_no_pop", bus.req_rd_en, 1'b0);
        repeat (3) tick();
        check("rst_no_rsp", rsp_cnt, r0);
        check("rst_outputs", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata,
                              bus.rsp_wr_en, bus.rsp_data}, '0);
        rst_n = 1'b1;
        wait_idle("rst_recover", 50);
        check("rst_recover_rsps", rsp_cnt - r0, 1);
        check("rst_recover_pops", pop_cnt - p0, 1);

`ifdef APB_TIMEOUT_EN
        push_req(1'b0, 32'h70, 32'h0, 1000, 32'h1357_9BDF, 1'b0);
        wait_idle("timeout", 100);
        check("timeout_access_len", last_len, TO + 1);
        check("timeout_rsp", bus.rsp_data, {1'b1, 32'h0});
`endif

        check("scoreboard_drained", rsp_q.size() + xfer_q.size() + req_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_req_master.md
Name: apb_req_master

Overview:
- APB initiator at the drain end of a request APB_FIFO. It pops one request word per transfer from a first-word-fall-through FIFO and drives a single APB3 transfer with that word.
- The completion response is pushed into a response APB_FIFO.
- Sits between the interconnect's request buffering and the APB slave-side bus segment.
- Only one transfer is outstanding at any time.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data width.
- REQ_WIDTH, 1+ADDR_WIDTH+DATA_WIDTH, request word layout: {write, addr, wdata}, with write at the MSB.
- TIMEOUT_CYCLES, 16, maximum ACCESS wait cycles. Used only when APB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_empty  input  1  request FIFO empty.
- req_data  input  REQ_WIDTH  request FIFO head word. Valid when req_empty=0.
- req_rd_en  output  1  request FIFO pop, combinational.
- rsp_full  input  1  response FIFO full.
- rsp_wr_en  output  1  response FIFO push, one-cycle pulse.
- rsp_data  output  DATA_WIDTH+1  response word {err, rdata}.
- psel  output  1  APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_WIDTH  APB address.
- pwdata  output  DATA_WIDTH  APB write data.
- pready  input  1  APB ready.
- prdata  input  DATA_WIDTH  APB read data.
- pslverr  input  1  APB slave error.

Behaviour:
- Reset (asynchronous, takes effect immediately on rst_n low):
  - State goes to IDLE.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_wr_en=0, rsp_data=0.
  - req_rd_en=0 while in reset.
  - A transfer in flight when reset asserts is dropped: no response, no pop.
- States are IDLE, SETUP and ACCESS.
- launch_ok = !req_empty && !rsp_full.
  - The response FIFO is written only by this block, so checking for room at launch guarantees space at completion.
- IDLE:
  - psel=0, penable=0.
  - If launch_ok: req_rd_en=1 in the same cycle. pwrite/paddr/pwdata register req_data on that edge, and the next state is SETUP.
  - Otherwise stay in IDLE.
- SETUP:
  - psel=1, penable=0 for exactly one cycle, then ACCESS unconditionally.
- ACCESS:
  - psel=1, penable=1. paddr, pwrite and pwdata are held stable.
  - pready=0: stay in ACCESS.
  - pready=1: the transfer completes on that edge.
    - rsp_wr_en pulses for one cycle in the following cycle.
    - rsp_data = {pslverr, prdata} for reads and {pslverr, 0} for writes. It is registered at completion and held until the next completion.
  - Back-to-back: if pready=1 and launch_ok, req_rd_en=1 in the same cycle, the next request is registered, and the next state is SETUP. psel stays 1 and penable drops to 0.
  - If pready=1 and not launch_ok, the next state is IDLE.
- Latency:
  - Request available in cycle N → SETUP in N+1, ACCESS in N+2.
  - With zero wait states, completion is at N+2 and rsp_wr_en is at N+3.
  - Minimum period is 2 cycles per transfer when back-to-back.
- req_rd_en is never asserted when req_empty=1. rsp_wr_en is never asserted when rsp_full=1 at launch time.
- pslverr is sampled only when psel&penable&pready. prdata is sampled likewise, and only for reads.
- pready is ignored outside ACCESS.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYCLES with pready still 0, the transfer is forced complete: rsp_data={1,0}, rsp_wr_en pulses, and the next state follows the normal completion rules.
  - pready=1 on the same cycle the counter reaches TIMEOUT_CYCLES takes priority: normal completion.
- Not defined: no counter exists, and ACCESS waits indefinitely for pready.

Test Plan:
- Single write: push {1,0x10,0xA5A5A5A5}, pready=1 → one SETUP cycle then one ACCESS cycle with paddr=0x10, pwdata=0xA5A5A5A5, pwrite=1; one rsp_wr_en with rsp_data={0,0}.
- Read with 3 wait states: push {0,0x20,x}, pready low for 3 ACCESS cycles, then high with prdata=0xDEADBEEF → ACCESS lasts 4 cycles, address stable throughout; rsp_data={0,0xDEADBEEF}.
- Back-to-back: FIFO holds 3 requests, pready=1 → psel high for 6 consecutive cycles with penable pattern 0,1,0,1,0,1; 3 pops; 3 responses in order.
- Backpressure: rsp_full=1 with a request pending → no pop, psel=0. Release rsp_full → SETUP on the next cycle.
- Slave error: read returns pslverr=1, prdata=0x1234 → rsp_data={1,0x1234}. The next request proceeds normally.
- Reset mid-ACCESS: assert rst_n=0 while pready=0 → psel/penable go 0 immediately; no response is written. With APB_TIMEOUT_EN defined and pready held 0 → rsp_data={1,0} after exactly 16 wait cycles.
